// File: rtl/uart_tx_byte_if.sv
// uart_tx_byte_if: request/response handshake between a byte producer and the UART transmitter
// Signals: tx_en request, tx_data byte, tx_ready idle/accepting, tx_valid end-of-frame pulse
// Modports: master = requester (drives tx_en/tx_data), slave = transmitter (drives tx_ready/tx_valid)
interface uart_tx_byte_if;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_valid;
    modport master (output tx_en, output tx_data, input tx_ready, input tx_valid);
    modport slave (input tx_en, input tx_data, output tx_ready, output tx_valid);
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: UART transmitter sending one frame (start, 8 data LSB first, optional parity, 1-2 stop) per accepted request
// Ports: clk_in system clock; n_rst async active-low reset; bus (slave) tx_en/tx_data in, tx_ready/tx_valid out;
//        tx serial line, idle high. All outputs registered.
module uart_tx_byte #(
    parameter int CLK_FREQ  = 96000000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          clk_in,
    input  logic          n_rst,
    uart_tx_byte_if.slave bus,
    output logic          tx
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT);

    if (PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2) || CLKS_PER_BIT < 2) begin : g_bad_param
        $error("uart_tx_byte: illegal parameters PARITY=%0d STOP_BITS=%0d CLKS_PER_BIT=%0d", PARITY, STOP_BITS, CLKS_PER_BIT);
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift, shift_n;
    logic          par, par_n;
    logic          tx_n;
    logic          ready, ready_n;
    logic          valid, valid_n;
    logic          wrap;

    assign wrap = baud_cnt == CW'(CLKS_PER_BIT - 1);
    assign bus.tx_ready = ready;
    assign bus.tx_valid = valid;

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            tx       <= 1'b1;
            ready    <= 1'b1;
            valid    <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            par      <= par_n;
            tx       <= tx_n;
            ready    <= ready_n;
            valid    <= valid_n;
        end
    end

    // tx is registered, so each transition loads the level of the bit being entered
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        par_n   = par;
        tx_n    = tx;
        ready_n = ready;
        valid_n = 1'b0;
        if (state == S_IDLE) begin
            if (bus.tx_en && ready) begin
                state_n = S_START;
                shift_n = bus.tx_data;
                par_n   = (PARITY == 1) ? ~^bus.tx_data : ^bus.tx_data;
                baud_n  = '0;
                bit_n   = '0;
                tx_n    = 1'b0;
                ready_n = 1'b0;
            end
        end else begin
            baud_n = wrap ? '0 : baud_cnt + CW'(1);
            if (wrap) begin
                case (state)
                    S_START: begin
                        state_n = S_DATA;
                        tx_n    = shift[0];
                    end
                    S_DATA: begin
                        if (bit_cnt == 3'd7) begin
                            state_n = (PARITY != 0) ? S_PAR : S_STOP;
                            tx_n    = (PARITY != 0) ? par : 1'b1;
                            bit_n   = '0;
                        end else begin
                            shift_n = {1'b0, shift[7:1]};
                            tx_n    = shift[1];
                            bit_n   = bit_cnt + 3'd1;
                        end
                    end
                    S_PAR: begin
                        state_n = S_STOP;
                        tx_n    = 1'b1;
                    end
                    S_STOP: begin
                        if (bit_cnt == 3'(STOP_BITS - 1)) begin
                            state_n = S_IDLE;
                            bit_n   = '0;
                            ready_n = 1'b1;
                            valid_n = 1'b1;
                        end else begin
                            bit_n = bit_cnt + 3'd1;
                        end
                    end
                    default: state_n = S_IDLE;
                endcase
            end
        end
    end
endmodule
